// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO.
// Responds on the data-memory bus inside the window flagged by sel.
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        mem_d_we,
  input  logic [3:0]  mem_d_wmask,
  input  logic [31:0] mem_d_a,
  input  logic [31:0] mem_d_wd,
  output logic [31:0] mem_d_rd,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_n;

  logic [7:0]    fifo [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;

  logic [15:0] div;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_n;
  logic        ovf;
  logic        irq_en;

  logic       wr;
  logic [1:0] reg_sel;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       busy;
  logic       bit_end;

  logic unused;
  assign unused = ^{mem_d_a[31:4], mem_d_a[1:0],
                    mem_d_wd[31:16], mem_d_wmask[3:2]};

  assign wr       = sel & mem_d_we;
  assign reg_sel  = mem_d_a[3:2];
  assign push_req = wr & (reg_sel == 2'd0) & mem_d_wmask[0];
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // Fullness is judged before any pop in the same cycle.
  assign push     = push_req & ~full;
  assign busy     = (state != IDLE);
  assign irq      = irq_en & empty & ~busy;
  assign bit_end  = (cnt >= div);

  // FIFO storage; no reset needed on the data array
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_d_wd[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control/status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf    <= 1'b0;
      div    <= DEFAULT_DIV;
      irq_en <= 1'b0;
    end else begin
      if (push_req & full) ovf <= 1'b1;
      if (wr) begin
        case (reg_sel)
          2'd1: if (mem_d_wmask[0] & mem_d_wd[3]) ovf <= 1'b0;
          2'd2: begin
            if (mem_d_wmask[0]) div[7:0]  <= mem_d_wd[7:0];
            if (mem_d_wmask[1]) div[15:8] <= mem_d_wd[15:8];
          end
          2'd3: if (mem_d_wmask[0]) irq_en <= mem_d_wd[0];
          default: ;
        endcase
      end
    end
  end

  // Transmitter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      tx    <= tx_n;
    end
  end

  // Transmitter next-state logic; pops the FIFO head from IDLE
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    tx_n    = tx;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = fifo[rd_ptr];
          cnt_n   = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = shreg[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
            idx_n   = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
    endcase
  end

  // Side-effect-free register read mux
  always_comb begin
    mem_d_rd = '0;
    if (sel) begin
      case (reg_sel)
        2'd1: mem_d_rd = {16'h0, 8'(count), 4'h0,
                          ovf, full, empty, busy};
        2'd2: mem_d_rd = {16'h0, div};
        2'd3: mem_d_rd = {31'h0, irq_en};
        default: mem_d_rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised and directed bench for mmio_uart_tx.
// A frame-level reference model predicts tx, irq and every register.
module tb_mmio_uart_tx;

  localparam int          DEPTH = 8;
  localparam logic [15:0] DDIV  = 16'd867;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [3:0]  wmask;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx;
  logic        irq;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(DDIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .mem_d_we   (we),
    .mem_d_wmask(wmask),
    .mem_d_a    (a),
    .mem_d_wd   (wd),
    .mem_d_rd   (rd),
    .tx         (tx),
    .irq        (irq)
  );

  int checks = 0;
  int errors = 0;

  // reference model: queue of bytes plus position inside the frame
  byte unsigned mq[$];
  bit           m_ovf  = 1'b0;
  logic [15:0]  m_div  = 16'd0;
  bit           m_en   = 1'b0;
  bit           m_busy = 1'b0;
  int           m_pos  = 0;
  logic [7:0]   m_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bit_time();
    return int'(m_div) + 1;
  endfunction

  function automatic logic m_tx();
    int k;
    if (!m_busy) return 1'b1;
    k = m_pos / bit_time();
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[3'(k-1)];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_rd(input int r);
    case (r)
      1: return {16'h0, 8'(mq.size()), 4'h0, m_ovf,
                 mq.size() == DEPTH, mq.size() == 0, m_busy};
      2: return {16'h0, m_div};
      3: return {31'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  // advance the model by one clock edge using the inputs held there
  task automatic model_step();
    bit do_pop;
    bit room;
    if (reset) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_div  = DDIV;
      m_en   = 1'b0;
      m_busy = 1'b0;
      m_pos  = 0;
      return;
    end
    do_pop = !m_busy && mq.size() > 0;
    room   = mq.size() < DEPTH;
    if (m_busy) begin
      m_pos++;
      if (m_pos >= 10 * bit_time()) m_busy = 1'b0;
    end else if (do_pop) begin
      m_byte = mq.pop_front();
      m_busy = 1'b1;
      m_pos  = 0;
    end
    if (sel && we) begin
      case (a[3:2])
        2'd0: if (wmask[0]) begin
          if (room) mq.push_back(wd[7:0]);
          else m_ovf = 1'b1;
        end
        2'd1: if (wmask[0] && wd[3]) m_ovf = 1'b0;
        2'd2: begin
          if (wmask[0]) m_div[7:0]  = wd[7:0];
          if (wmask[1]) m_div[15:8] = wd[15:8];
        end
        default: if (wmask[0]) m_en = wd[0];
      endcase
    end
  endtask

  task automatic check_all();
    logic [31:0] hi;
    chk("tx", tx, m_tx());
    chk("irq", irq, m_en && mq.size() == 0 && !m_busy);
    sel   = 1'b1;
    we    = 1'b0;
    wmask = 4'h0;
    for (int i = 0; i < 4; i++) begin
      hi = $urandom;
      a  = (hi & ~32'hC) | (32'(i) << 2);
      #1;
      chk($sformatf("rd%0d", i), rd, m_rd(i));
    end
    sel = 1'b0;
    a   = $urandom;
    #1;
    chk("rd_nosel", rd, 32'h0);
  endtask

  task automatic drive(input logic s, input logic w, input logic [3:0] m,
                       input logic [31:0] ad, input logic [31:0] d);
    sel   = s;
    we    = w;
    wmask = m;
    a     = ad;
    wd    = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic step();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
  endtask

  task automatic wr(input logic [31:0] ad, input logic [3:0] m,
                    input logic [31:0] d);
    drive(1'b1, 1'b1, m, ad, d);
    cycle();
  endtask

  task automatic rd_at(input logic [31:0] ad, output logic [31:0] v);
    drive(1'b1, 1'b0, 4'h0, ad, 32'h0);
    #1;
    v = rd;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((m_busy || mq.size() > 0) && n < limit) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(n < limit), 32'h1);
  endtask

  logic [31:0] v;
  logic [9:0]  p1;
  logic [9:0]  p2;
  logic        e;
  int          n;
  int          r;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    cycle();
    reset = 1'b0;
    rd_at(32'h4, v);
    chk("rst_status", v, 32'h2);
    rd_at(32'h8, v);
    chk("rst_div", v, 32'd867);
    chk("rst_tx", tx, 1'b1);
    chk("rst_irq", irq, 1'b0);

    // single frame 0xA5 at four clocks per bit
    wr(32'h8, 4'b0011, 32'd3);
    wr(32'h0, 4'b0001, 32'hA5);
    p1 = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      step();
      chk("a5_tx", tx, p1[i/4]);
    end
    step();
    rd_at(32'h4, v);
    chk("a5_busy", v[0], 1'b0);

    // fill the FIFO, then overflow it
    wr(32'h8, 4'b0011, 32'd0);
    for (int i = 0; i < DEPTH + 1; i++)
      wr(32'h0, 4'b0001, $urandom_range(0, 255));
    rd_at(32'h4, v);
    chk("fill_cnt", v[15:8], DEPTH);
    chk("fill_ovf", v[3], 1'b0);
    wr(32'h0, 4'b0001, 32'h11);
    wr(32'h0, 4'b0001, 32'h22);
    rd_at(32'h4, v);
    chk("ovf_set", v[3], 1'b1);
    chk("ovf_cnt", v[15:8], DEPTH);
    wr(32'h4, 4'b0001, 32'h8);
    rd_at(32'h4, v);
    chk("ovf_clr", v[3], 1'b0);
    wait_idle(300);

    // back-to-back frames, one idle cycle between them
    wr(32'h8, 4'b0011, 32'd1);
    p1 = {1'b1, 8'h01, 1'b0};
    p2 = {1'b1, 8'h80, 1'b0};
    wr(32'h0, 4'b0001, 32'h01);
    drive(1'b1, 1'b1, 4'b0001, 32'h0, 32'h80);
    cycle();
    chk("b2b_tx", tx, p1[0]);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i < 20) e = p1[i/2];
      else if (i == 20) e = 1'b1;
      else e = p2[(i-21)/2];
      chk("b2b_tx", tx, e);
      if (i == 20) begin
        rd_at(32'h4, v);
        chk("b2b_gap_busy", v[0], 1'b0);
      end
    end
    wait_idle(100);

    // drain interrupt
    wr(32'hC, 4'b0001, 32'h1);
    wr(32'h0, 4'b0001, 32'h3C);
    chk("irq_pending", irq, 1'b0);
    for (int i = 0; i <= 20; i++) begin
      step();
      chk("irq_seq", irq, i == 20);
    end
    wr(32'hC, 4'b0001, 32'h0);
    chk("irq_off", irq, 1'b0);

    // reset in the middle of data bit 3
    wr(32'h8, 4'b0011, 32'd3);
    wr(32'h0, 4'b0001, 32'h5A);
    n = 0;
    while (!(m_busy && m_pos / bit_time() == 4) && n < 200) begin
      step();
      n++;
    end
    chk("reach_bit3", 32'(n < 200), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_irq", irq, 1'b0);
    rd_at(32'h4, v);
    chk("mid_rst_status", v, 32'h2);
    rd_at(32'h8, v);
    chk("mid_rst_div", v, 32'd867);
    for (int i = 0; i < 60; i++) begin
      step();
      chk("post_rst_tx", tx, 1'b1);
    end

    // randomised traffic
    wr(32'h8, 4'b0011, 32'd1);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)
        drive(1'b1, 1'b1, 4'($urandom_range(0, 15)) | 4'(r < 30),
              32'h0, $urandom);
      else if (r < 40 && !m_busy && mq.size() == 0)
        drive(1'b1, 1'b1, 4'b0011, 32'h8, $urandom_range(0, 3));
      else if (r < 45)
        drive(1'b1, 1'b1, 4'($urandom_range(0, 15)), 32'hC, $urandom);
      else if (r < 50)
        drive(1'b1, 1'b1, 4'($urandom_range(0, 15)), 32'h4, $urandom);
      else if (r < 55)
        drive(1'b1, 1'b1, 4'h0, $urandom & 32'hC, $urandom);
      else if (r < 60)
        drive(1'b0, 1'b1, 4'($urandom_range(0, 15)),
              $urandom & 32'hC, $urandom);
      else
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      cycle();
    end
    wait_idle(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
